// File: rtl/gelu_pwl_stream.sv
// Multi-lane two-stage piecewise-linear GELU/ReLU with valid/ready flow control.
// Define GELU_PWL_CNT_EN to add the beat_cnt output-beat counter and its cnt_clr input.

module gelu_pwl_lane #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ld1_i,
  input  logic                     ld2_i,
  input  logic                     mode1_i,
  input  logic signed [DATA_W-1:0] x_i,
  output logic signed [DATA_W-1:0] y_o
);
  localparam int EW = DATA_W + 2;
  localparam int K  = 1 << FRAC_W;
  localparam logic signed [EW-1:0]     P3K    = EW'(3 * K);
  localparam logic signed [EW-1:0]     M3K    = EW'(-3 * K);
  localparam logic signed [EW-1:0]     MK     = EW'(-K);
  localparam logic signed [EW-1:0]     MK2    = EW'(-(K / 2));
  localparam logic signed [DATA_W-1:0] NEG_K8 = DATA_W'(-(K / 8));

  typedef enum logic [2:0] {SEG_ZERO, SEG_TAIL, SEG_FLAT, SEG_KNEE, SEG_POS} seg_e;

  logic signed [EW-1:0]     xe, sum;
  seg_e                     seg_d, seg_q;
  logic signed [DATA_W-1:0] tail_d, tail_q, qtr_d, qtr_q, x_q, y_d, y_q;

  always_comb begin
    xe     = {{2{x_i[DATA_W-1]}}, x_i};
    sum    = xe + P3K;
    tail_d = DATA_W'(-(sum >>> 4));
    qtr_d  = x_i >>> 2;
    if (xe <= M3K)          seg_d = SEG_ZERO;
    else if (xe < MK)       seg_d = SEG_TAIL;
    else if (xe < MK2)      seg_d = SEG_FLAT;
    else if (x_i[DATA_W-1]) seg_d = SEG_KNEE;
    else                    seg_d = SEG_POS;
  end

  // ReLU only needs the sign, which SEG_POS already encodes.
  always_comb begin
    y_d = '0;
    if (mode1_i) begin
      if (seg_q == SEG_POS) y_d = x_q;
    end else begin
      case (seg_q)
        SEG_TAIL: y_d = tail_q;
        SEG_FLAT: y_d = NEG_K8;
        SEG_KNEE: y_d = qtr_q;
        SEG_POS:  y_d = x_q;
        default:  y_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q  <= SEG_ZERO;
      tail_q <= '0;
      qtr_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      if (ld1_i) begin
        seg_q  <= seg_d;
        tail_q <= tail_d;
        qtr_q  <= qtr_d;
        x_q    <= x_i;
      end
      if (ld2_i) y_q <= y_d;
    end
  end

  assign y_o = y_q;
endmodule

module gelu_pwl_stream #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 5,
  parameter int LANES  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [LANES*DATA_W-1:0] x_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] y_out
`ifdef GELU_PWL_CNT_EN
  ,
  output logic [31:0]             beat_cnt,
  input  logic                    cnt_clr
`endif
);
  localparam int STAGES = 2;

  logic [STAGES:1] vld_d, vld_q;
  logic            mode_q;
  logic            adv1, adv2, ld1, ld2;

  // Each stage moves when empty or when its successor moves.
  always_comb begin
    adv2     = !vld_q[2] || out_ready;
    adv1     = !vld_q[1] || adv2;
    ld1      = in_valid && adv1;
    ld2      = vld_q[1] && adv2;
    vld_d[1] = adv1 ? in_valid : vld_q[1];
    vld_d[2] = adv2 ? vld_q[1] : vld_q[2];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (ld1) mode_q <= in_mode;
    end
  end

  assign in_ready  = adv1;
  assign out_valid = vld_q[STAGES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gelu_pwl_lane #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .ld1_i   (ld1),
      .ld2_i   (ld2),
      .mode1_i (mode_q),
      .x_i     (x_in[i*DATA_W +: DATA_W]),
      .y_o     (y_out[i*DATA_W +: DATA_W])
    );
  end

`ifdef GELU_PWL_CNT_EN
  logic [31:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                     cnt_d = '0;
    else if (out_valid && out_ready) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign beat_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_gelu_pwl_stream.sv
// Directed bench for gelu_pwl_stream (DATA_W=8, FRAC_W=5, LANES=4).
module tb_gelu_pwl_stream;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_mode, out_valid, out_ready;
  logic [31:0] x_in, y_out;
`ifdef GELU_PWL_CNT_EN
  logic [31:0] beat_cnt;
  logic        cnt_clr;
`endif
  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gelu_pwl_stream #(.DATA_W(8), .FRAC_W(5), .LANES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out)
`ifdef GELU_PWL_CNT_EN
    ,
    .beat_cnt  (beat_cnt),
    .cnt_clr   (cnt_clr)
`endif
  );

  function automatic logic [31:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; in_valid = 1'b0; in_mode = 1'b0; x_in = '0; out_ready = 1'b1;
`ifdef GELU_PWL_CNT_EN
    cnt_clr = 1'b0;
`endif
    tick; tick;
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_run++; if (y_out !== 32'h0) begin n_fail++; $display("FAIL reset_y_out: got %h want 0", y_out); end
`ifdef GELU_PWL_CNT_EN
    n_run++; if (beat_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_beat_cnt: got %0d want 0", beat_cnt); end
`endif
    reset = 1'b1;
    #1;
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tick;
  endtask

  task automatic test_gelu;
    logic [31:0] bx[4], by[4];
    bx[0] = pk(-128, -64, -48, -32); by[0] = pk(0, -2, -3, -4);
    bx[1] = pk(-16, -8, -1, 100);    by[1] = pk(-4, -2, -1, 100);
    bx[2] = pk(-96, -95, -33, -17);  by[2] = pk(0, 0, -3, -4);
    bx[3] = pk(-97, -65, -16, 0);    by[3] = pk(0, -1, -4, 0);
    out_ready = 1'b1; in_mode = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 4);
      x_in = (c < 4) ? bx[c] : 32'h0;
      #1;
      if (c < 4) begin
        n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL gelu_in_ready c%0d: got %b want 1", c, in_ready); end
      end
      if (c >= 2) begin
        n_run++; if (out_valid !== 1'b1 || y_out !== by[c-2]) begin n_fail++; $display("FAIL gelu_beat%0d: got v=%b y=%h want v=1 y=%h", c-2, out_valid, y_out, by[c-2]); end
      end else begin
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gelu_latency c%0d: got v=%b want 0", c, out_valid); end
      end
      tick;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_relu_mix;
    logic [31:0] bx[4], by[4];
    logic        bm[4];
    bx[0] = pk(-16, -1, 0, 127);     bm[0] = 1'b1; by[0] = pk(0, 0, 0, 127);
    bx[1] = pk(-16, -1, 0, 127);     bm[1] = 1'b0; by[1] = pk(-4, -1, 0, 127);
    bx[2] = pk(-64, -48, 5, -128);   bm[2] = 1'b1; by[2] = pk(0, 0, 5, 0);
    bx[3] = pk(-64, -48, 5, -128);   bm[3] = 1'b0; by[3] = pk(-2, -3, 5, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 4);
      x_in = (c < 4) ? bx[c] : 32'h0;
      in_mode = (c < 4) ? bm[c] : 1'b0;
      #1;
      if (c >= 2) begin
        n_run++; if (out_valid !== 1'b1 || y_out !== by[c-2]) begin n_fail++; $display("FAIL mix_beat%0d: got v=%b y=%h want v=1 y=%h", c-2, out_valid, y_out, by[c-2]); end
      end
      tick;
    end
    in_valid = 1'b0; in_mode = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [15:0] pat = 16'b0011_0100_1101_0001;
    int          snt = 0, rcv = 0, occ, stalls = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_y = '0;
    in_mode = 1'b0;
    for (int cyc = 0; cyc < 200 && rcv < 10; cyc++) begin
      out_ready = pat[cyc % 16];
      in_valid  = (snt < 10) && (cyc % 7 != 4);
      x_in      = pk(snt + 1, 2 * (snt + 1), 3 * (snt + 1), 4 * (snt + 1));
      #1;
      occ = snt - rcv;
      if (in_ready === 1'b0) stalls++;
      n_run++; if (in_ready !== !(occ == 2 && !out_ready)) begin n_fail++; $display("FAIL bp_in_ready cyc%0d: got %b occ=%0d out_ready=%b", cyc, in_ready, occ, out_ready); end
      if (stall_prev) begin
        n_run++; if (out_valid !== 1'b1 || y_out !== prev_y) begin n_fail++; $display("FAIL bp_stable cyc%0d: got v=%b y=%h want v=1 y=%h", cyc, out_valid, y_out, prev_y); end
      end
      if (out_valid === 1'b1) begin
        n_run++; if (rcv >= 10 || y_out !== pk(rcv + 1, 2 * (rcv + 1), 3 * (rcv + 1), 4 * (rcv + 1))) begin n_fail++; $display("FAIL bp_order beat%0d: got %h", rcv + 1, y_out); end
      end
      stall_prev = out_valid && !out_ready;
      prev_y = y_out;
      if (in_valid && in_ready) snt++;
      if (out_valid && out_ready) rcv++;
      tick;
    end
    n_run++; if (rcv != 10) begin n_fail++; $display("FAIL bp_count: got %0d beats want 10", rcv); end
    n_run++; if (stalls == 0) begin n_fail++; $display("FAIL bp_full_stall: got 0 full-stall cycles want >0"); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b1; in_mode = 1'b0;
    in_valid = 1'b1; x_in = pk(1, 2, 3, 4); tick;
    x_in = pk(5, 6, 7, 8); tick;
    in_valid = 1'b0; x_in = '0;
    n_run++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_inflight: got v=%b want 1", out_valid); end
    reset = 1'b0;
    #1;
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    n_run++; if (y_out !== 32'h0) begin n_fail++; $display("FAIL mid_y_out: got %h want 0", y_out); end
    tick;
    reset = 1'b1;
    in_valid = 1'b1; x_in = pk(-16, -8, -1, 100);
    #1;
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0; x_in = '0;
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale: got v=%b y=%h want v=0", out_valid, y_out); end
    tick;
    n_run++; if (out_valid !== 1'b1 || y_out !== pk(-4, -2, -1, 100)) begin n_fail++; $display("FAIL mid_first: got v=%b y=%h want v=1 y=%h", out_valid, y_out, pk(-4, -2, -1, 100)); end
    tick;
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_dup: got v=%b want 0", out_valid); end
  endtask

`ifdef GELU_PWL_CNT_EN
  task automatic test_counter;
    reset = 1'b0; #1; reset = 1'b1;
    out_ready = 1'b1; in_mode = 1'b0; cnt_clr = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 5);
      x_in = pk(c, c, c, c);
      tick;
    end
    in_valid = 1'b0;
    n_run++; if (beat_cnt !== 32'd5) begin n_fail++; $display("FAIL cnt_five: got %0d want 5", beat_cnt); end
    in_valid = 1'b1; x_in = pk(9, 9, 9, 9); tick;
    in_valid = 1'b0; tick;
    cnt_clr = 1'b1;
    #1;
    n_run++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL cnt_sixth_valid: got %b want 1", out_valid); end
    tick;
    cnt_clr = 1'b0;
    n_run++; if (beat_cnt !== 32'd0) begin n_fail++; $display("FAIL cnt_clr: got %0d want 0", beat_cnt); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_gelu;
    test_relu_mix;
    test_backpressure;
    test_reset_midstream;
`ifdef GELU_PWL_CNT_EN
    test_counter;
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
